// File: rtl/xocc_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : xocc_cmd_dispatcher
// Brief    : Pops XOCC channel-1 commands, runs EXEC on a DSA accelerator with
//            a completion timeout and packs 1- or 2-word results into responses.
// Revision : 1.0 - initial release
// ============================================================================
module xocc_cmd_dispatcher #(
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic             i_pad_clk,
    input  logic             i_pad_rst_b,
    input  logic [95:0]      cmd_buffer,
    input  logic             cmd_empty,
    output logic             cmd_rd_en,
    output logic [31:0]      rsp_buffer,
    output logic             rsp_wr_en,
    input  logic             rsp_full,
    output logic             acc_req_valid,
    input  logic             acc_req_ready,
    output logic [31:0]      acc_req_op_a,
    output logic [31:0]      acc_req_op_b,
    output logic [7:0]       acc_req_tag,
    input  logic             acc_rsp_valid,
    output logic             acc_rsp_ready,
    input  logic [31:0]      acc_rsp_data,
    output logic             acc_abort,
    output logic             busy,
    output logic [CNT_W-1:0] cmd_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [7:0] C_OP_NOP     = 8'h00;
    localparam logic [7:0] C_OP_EXEC    = 8'h01;
    localparam logic [7:0] C_ST_OK      = 8'h00;
    localparam logic [7:0] C_ST_TIMEOUT = 8'h01;
    localparam logic [7:0] C_ST_ILLEGAL = 8'h02;
    localparam int         C_TMR_W      = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ISSUE    = 3'd1,
        S_WAIT_RSP = 3'd2,
        S_HDR      = 3'd3,
        S_DATA     = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_opcode;
    logic [7:0]         r_tag;
    logic [31:0]        r_op_a;
    logic [31:0]        r_op_b;
    logic [31:0]        r_result;
    logic [7:0]         r_status;
    logic [C_TMR_W-1:0] r_timer;
    logic [CNT_W-1:0]   r_cmd_count;
    logic [CNT_W-1:0]   r_err_count;

    logic               w_pop;
    logic               w_req_valid;
    logic               w_rsp_ready;
    logic               w_abort;
    logic               w_wr;
    logic               w_rsp_accept;
    logic               w_timeout;
    logic [7:0]         w_beats;
    logic [7:0]         w_new_op;
    logic [31:0]        w_header;
    logic [31:0]        w_rsp_word;
    logic               w_unused_rsvd;

    assign w_unused_rsvd = ^cmd_buffer[31:16];
    assign w_new_op      = cmd_buffer[7:0];

    // A zero TIMEOUT_CYC leaves the timer free-running but never matched.
    assign w_timeout = (TIMEOUT_CYC != 0) && (r_timer == C_TMR_W'(TIMEOUT_CYC));
    assign w_beats   = ((r_opcode == C_OP_EXEC) && (r_status == C_ST_OK)) ? 8'd1 : 8'd0;
    assign w_header  = {r_tag, r_opcode, r_status, w_beats};

    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_req_valid  = 1'b0;
        w_rsp_ready  = 1'b0;
        w_abort      = 1'b0;
        w_wr         = 1'b0;
        w_rsp_accept = 1'b0;
        w_rsp_word   = '0;
        case (r_state)
            S_IDLE: begin
                if (!cmd_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = (w_new_op == C_OP_EXEC) ? S_ISSUE : S_HDR;
                end
            end
            S_ISSUE: begin
                w_req_valid = 1'b1;
                if (w_timeout) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_HDR;
                end else if (acc_req_ready) begin
                    w_state_nxt = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                w_rsp_ready = 1'b1;
                // A result arriving on the timeout cycle still counts as a completion.
                if (acc_rsp_valid) begin
                    w_rsp_accept = 1'b1;
                    w_state_nxt  = S_HDR;
                end else if (w_timeout) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_HDR;
                end
            end
            S_HDR: begin
                w_rsp_word = w_header;
                if (!rsp_full) begin
                    w_wr        = 1'b1;
                    w_state_nxt = w_beats[0] ? S_DATA : S_IDLE;
                end
            end
            S_DATA: begin
                w_rsp_word = r_result;
                if (!rsp_full) begin
                    w_wr        = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_pad_clk) begin
        if (!i_pad_rst_b) begin
            r_state     <= S_IDLE;
            r_opcode    <= '0;
            r_tag       <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_result    <= '0;
            r_status    <= C_ST_OK;
            r_timer     <= '0;
            r_cmd_count <= '0;
            r_err_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_opcode    <= w_new_op;
                r_tag       <= cmd_buffer[15:8];
                r_op_a      <= cmd_buffer[63:32];
                r_op_b      <= cmd_buffer[95:64];
                r_status    <= ((w_new_op == C_OP_NOP) || (w_new_op == C_OP_EXEC)) ?
                               C_ST_OK : C_ST_ILLEGAL;
                r_cmd_count <= r_cmd_count + CNT_W'(1);
                r_timer     <= '0;
            end else if ((r_state == S_ISSUE) || (r_state == S_WAIT_RSP)) begin
                r_timer <= r_timer + C_TMR_W'(1);
            end
            if (w_rsp_accept) begin
                r_result <= acc_rsp_data;
                r_status <= C_ST_OK;
            end else if (w_abort) begin
                r_status <= C_ST_TIMEOUT;
            end
            if (w_wr && (r_state == S_HDR) && (r_status != C_ST_OK)) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
        end
    end

    // Handshakes are held low while reset is asserted, so nothing is popped,
    // written or aborted on a reset edge.
    assign cmd_rd_en     = w_pop       & i_pad_rst_b;
    assign acc_req_valid = w_req_valid & i_pad_rst_b;
    assign acc_rsp_ready = w_rsp_ready & i_pad_rst_b;
    assign acc_abort     = w_abort     & i_pad_rst_b;
    assign rsp_wr_en     = w_wr        & i_pad_rst_b;
    assign rsp_buffer    = i_pad_rst_b ? w_rsp_word : '0;
    assign acc_req_op_a  = r_op_a;
    assign acc_req_op_b  = r_op_b;
    assign acc_req_tag   = r_tag;
    assign busy          = (r_state != S_IDLE);
    assign cmd_count     = r_cmd_count;
    assign err_count     = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_xocc_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_xocc_cmd_dispatcher
// Brief    : Scoreboard bench with a reference model and accelerator responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xocc_cmd_dispatcher;

    localparam int C_T  = 8;
    localparam int C_CW = 8;

    typedef struct {
        logic [95:0] cmd;
        int          d1;
        int          d2;
        logic [31:0] data;
        bit          victim;
    } item_t;

    logic            clk = 1'b0;
    logic            rst_b = 1'b0;
    logic [95:0]     cmd_buffer;
    logic            cmd_empty;
    logic            cmd_rd_en;
    logic [31:0]     rsp_buffer;
    logic            rsp_wr_en;
    logic            rsp_full = 1'b0;
    logic            acc_req_valid;
    logic            acc_req_ready;
    logic [31:0]     acc_req_op_a;
    logic [31:0]     acc_req_op_b;
    logic [7:0]      acc_req_tag;
    logic            acc_rsp_valid;
    logic            acc_rsp_ready;
    logic [31:0]     acc_rsp_data;
    logic            acc_abort;
    logic            busy;
    logic [C_CW-1:0] cmd_count;
    logic [C_CW-1:0] err_count;

    item_t       cmd_q[$];
    item_t       acc_q[$];
    logic [31:0] exp_q[$];
    int checks = 0, errors = 0;
    int m_cmds = 0, m_errs = 0, m_aborts = 0, seen_aborts = 0;
    bit full_force = 0, full_rand = 0, bubbles = 0;

    xocc_cmd_dispatcher #(.TIMEOUT_CYC(C_T), .CNT_W(C_CW)) dut (
        .i_pad_clk(clk), .i_pad_rst_b(rst_b),
        .cmd_buffer(cmd_buffer), .cmd_empty(cmd_empty), .cmd_rd_en(cmd_rd_en),
        .rsp_buffer(rsp_buffer), .rsp_wr_en(rsp_wr_en), .rsp_full(rsp_full),
        .acc_req_valid(acc_req_valid), .acc_req_ready(acc_req_ready),
        .acc_req_op_a(acc_req_op_a), .acc_req_op_b(acc_req_op_b), .acc_req_tag(acc_req_tag),
        .acc_rsp_valid(acc_rsp_valid), .acc_rsp_ready(acc_rsp_ready),
        .acc_rsp_data(acc_rsp_data), .acc_abort(acc_abort), .busy(busy),
        .cmd_count(cmd_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic item_t mk(input logic [95:0] cmd, input int d1, input int d2,
                                 input logic [31:0] data, input bit victim);
        item_t it;
        it.cmd = cmd; it.d1 = d1; it.d2 = d2; it.data = data; it.victim = victim;
        return it;
    endfunction

    function automatic item_t rand_item();
        int         r;
        logic [7:0] op;
        r  = $urandom_range(0, 9);
        op = (r < 4) ? 8'h01 : (r < 7) ? 8'h00 : 8'($urandom_range(2, 255));
        return mk({32'($urandom), 32'($urandom), 16'($urandom), 8'($urandom), op},
                  $urandom_range(0, 4), $urandom_range(0, 6), $urandom, 1'b0);
    endfunction

    // Reference model: the accelerator's planned delays decide OK versus timeout.
    task automatic model_issue(input item_t it);
        logic [7:0] op, tag;
        op  = it.cmd[7:0];
        tag = it.cmd[15:8];
        m_cmds++;
        if (it.victim) begin
            acc_q.push_back(it);
        end else if (op == 8'h00) begin
            exp_q.push_back({tag, 8'h00, 8'h00, 8'h00});
        end else if (op == 8'h01) begin
            acc_q.push_back(it);
            if (it.d1 + 1 + it.d2 > C_T) begin
                exp_q.push_back({tag, 8'h01, 8'h01, 8'h00});
                m_errs++;
                m_aborts++;
            end else begin
                exp_q.push_back({tag, 8'h01, 8'h00, 8'h01});
                exp_q.push_back(it.data);
            end
        end else begin
            exp_q.push_back({tag, op, 8'h02, 8'h00});
            m_errs++;
        end
    endtask

    initial begin : cmd_drv
        bit    pend;
        item_t drop;
        pend = 0;
        cmd_empty = 1'b1;
        cmd_buffer = '0;
        forever begin
            @(negedge clk);
            if (pend && cmd_q.size() > 0) drop = cmd_q.pop_front();
            pend = 0;
            if (cmd_q.size() == 0 || (bubbles && $urandom_range(0, 3) == 0)) begin
                cmd_empty = 1'b1;
            end else begin
                cmd_empty  = 1'b0;
                cmd_buffer = cmd_q[0].cmd;
            end
            #1;
            if (cmd_rd_en && !cmd_empty) begin
                model_issue(cmd_q[0]);
                pend = 1;
            end else if (cmd_rd_en) begin
                check("rd_en_while_empty", 32'(cmd_rd_en), 32'd0);
            end
        end
    end

    initial begin : full_drv
        forever begin
            @(negedge clk);
            rsp_full = full_force ? 1'b1 : (full_rand ? ($urandom_range(0, 3) == 0) : 1'b0);
        end
    end

    task automatic serve();
        item_t p;
        int    j, k;
        if (acc_q.size() == 0) begin
            check("unexpected_acc_req", 32'(acc_req_valid), 32'd0);
            while (acc_req_valid) begin
                @(negedge clk); #2;
            end
            return;
        end
        p = acc_q.pop_front();
        j = 0;
        forever begin
            check("req_valid_held", 32'(acc_req_valid), 32'd1);
            check("req_op_a", acc_req_op_a, p.cmd[63:32]);
            check("req_op_b", acc_req_op_b, p.cmd[95:64]);
            check("req_tag", 32'(acc_req_tag), 32'(p.cmd[15:8]));
            if (acc_abort) begin
                check("abort_cycle_issue", j, C_T);
                return;
            end
            if (j == p.d1) begin
                acc_req_ready = 1'b1;
                @(negedge clk); #2;
                acc_req_ready = 1'b0;
                break;
            end
            j++;
            @(negedge clk); #2;
        end
        k = 0;
        forever begin
            if (p.victim) begin
                if (!rst_b) return;
                if (acc_abort) check("victim_abort", 32'(acc_abort), 32'd0);
            end else begin
                check("rsp_ready", 32'(acc_rsp_ready), 32'd1);
                if (k == p.d2) begin
                    acc_rsp_valid = 1'b1;
                    acc_rsp_data  = p.data;
                    @(negedge clk); #2;
                    acc_rsp_valid = 1'b0;
                    return;
                end
                if (acc_abort) begin
                    check("abort_cycle_wait", p.d1 + 1 + k, C_T);
                    return;
                end
            end
            k++;
            @(negedge clk); #2;
        end
    endtask

    initial begin : acc_model
        acc_req_ready = 1'b0;
        acc_rsp_valid = 1'b0;
        acc_rsp_data  = '0;
        forever begin
            @(negedge clk); #2;
            if (acc_req_valid) serve();
        end
    end

    initial begin : rsp_mon
        forever begin
            @(negedge clk); #3;
            if (acc_abort) seen_aborts++;
            if (rsp_full) check("wr_while_full", 32'(rsp_wr_en), 32'd0);
            if (!rst_b) check("wr_during_reset", 32'(rsp_wr_en), 32'd0);
            if (rsp_wr_en && rst_b) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got %h expected no write", rsp_buffer);
                end else begin
                    check("rsp_word", rsp_buffer, exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk); #4;
            n++;
        end while (!(cmd_q.size() == 0 && exp_q.size() == 0 && !busy) && n < 20000);
        if (n >= 20000) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic wait_pop();
        int n;
        n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!cmd_rd_en && n < 100);
        if (n >= 100) check("pop_timeout", 32'(cmd_rd_en), 32'd1);
    endtask

    initial begin : watchdog
        repeat (80000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n;
        repeat (3) @(negedge clk);
        #4;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cmd_count", 32'(cmd_count), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_req_valid", 32'(acc_req_valid), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;

        // NOP: header one cycle after the pop
        cmd_q.push_back(mk({32'h0, 32'h0, 16'h0, 8'h3C, 8'h00}, 0, 0, 0, 0));
        wait_pop();
        @(negedge clk); #4;
        check("nop_latency", 32'(rsp_wr_en), 32'd1);
        wait_idle();
        check("nop_cmd_count", 32'(cmd_count), 32'd1);
        check("nop_err_count", 32'(err_count), 32'd0);

        cmd_q.push_back(mk({32'h0, 32'h0, 16'h0, 8'h11, 8'h7F}, 0, 0, 0, 0));
        wait_idle();
        check("illegal_err_count", 32'(err_count), 32'd1);

        cmd_q.push_back(mk({32'h20, 32'h10, 16'h0, 8'h05, 8'h01}, 3, 2, 32'h30, 0));
        wait_idle();

        cmd_q.push_back(mk({32'h20, 32'h10, 16'h0, 8'h05, 8'h01}, 0, 100, 32'h0, 0));
        wait_idle();
        check("timeout_err_count", 32'(err_count), 32'd2);
        check("timeout_aborts", seen_aborts, 1);

        // Response FIFO held full while an EXEC completes
        full_force = 1;
        cmd_q.push_back(mk({32'h2, 32'h1, 16'h0, 8'h22, 8'h01}, 0, 0, 32'hDEAD_BEEF, 0));
        cmd_q.push_back(mk({32'h0, 32'h0, 16'h0, 8'h33, 8'h00}, 0, 0, 0, 0));
        wait_pop();
        repeat (8) @(negedge clk);
        #4;
        check("full_no_pop", cmd_q.size(), 1);
        check("full_busy", 32'(busy), 32'd1);
        full_force = 0;
        wait_idle();

        // Reset during WAIT_RSP discards the in-flight command
        cmd_q.push_back(mk({32'h4, 32'h3, 16'h0, 8'h44, 8'h01}, 0, 0, 0, 1));
        n = 0;
        do begin
            @(negedge clk); #4;
            n++;
        end while (!acc_rsp_ready && n < 50);
        check("reached_wait", 32'(acc_rsp_ready), 32'd1);
        @(negedge clk);
        rst_b = 1'b0;
        m_cmds = 0;
        m_errs = 0;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        #4;
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_cmd_count", 32'(cmd_count), 32'd0);
        check("post_rst_err_count", 32'(err_count), 32'd0);
        repeat (4) @(negedge clk);

        // Counter wrap
        for (int i = 0; i < (1 << C_CW) - 1; i++)
            cmd_q.push_back(mk({32'h0, 32'h0, 16'h0, 8'($urandom), 8'h00}, 0, 0, 0, 0));
        wait_idle();
        check("cnt_max", 32'(cmd_count), 32'((1 << C_CW) - 1));
        cmd_q.push_back(mk({32'h0, 32'h0, 16'h0, 8'h55, 8'h00}, 0, 0, 0, 0));
        wait_idle();
        check("cnt_wrap", 32'(cmd_count), 32'd0);

        // Randomized traffic
        full_rand = 1;
        bubbles   = 1;
        for (int i = 0; i < 200; i++) cmd_q.push_back(rand_item());
        wait_idle();
        full_rand = 0;
        bubbles   = 0;
        repeat (2) @(negedge clk);
        #4;
        check("final_cmd_count", 32'(cmd_count), 32'(m_cmds % (1 << C_CW)));
        check("final_err_count", 32'(err_count), 32'(m_errs % (1 << C_CW)));
        check("final_aborts", seen_aborts, m_aborts);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
